// File: rtl/fp_class_pkg.sv
// Shared definitions for the floating-point classifier pipeline.
// Holds the one-hot class bit positions, the legal IEEE-754 field widths,
// the decoded-field record carried through stage S1, and the helper
// functions that turn decoded fields into a class.
package fp_class_pkg;

  localparam int NUM_CLASS = 10;

  // Bit positions inside out_class / counter slots inside cnt_bus.
  localparam int CLS_NINF  = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB  = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB  = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF  = 7;
  localparam int CLS_SNAN  = 8;
  localparam int CLS_QNAN  = 9;

  // Supported formats: half, single, double.
  localparam int HALF_EXP_W   = 5;
  localparam int HALF_MAN_W   = 10;
  localparam int SINGLE_EXP_W = 8;
  localparam int SINGLE_MAN_W = 23;
  localparam int DOUBLE_EXP_W = 11;
  localparam int DOUBLE_MAN_W = 52;

  typedef logic [NUM_CLASS-1:0] class_t;

  // Everything the classifier needs once the operand has been decoded;
  // independent of the operand width so S1 stays small for double too.
  typedef struct packed {
    logic sign;
    logic exp_one;
    logic exp_zero;
    logic man_zero;
    logic man_msb;
    logic daz;
  } fields_t;

  function automatic bit fmt_legal(input int exp_w, input int man_w);
    return (exp_w == HALF_EXP_W   && man_w == HALF_MAN_W)   ||
           (exp_w == SINGLE_EXP_W && man_w == SINGLE_MAN_W) ||
           (exp_w == DOUBLE_EXP_W && man_w == DOUBLE_MAN_W);
  endfunction

  // Exactly one bit is set for every input combination. NaNs drop the sign.
  function automatic class_t classify(input fields_t f);
    class_t cls;
    cls = '0;
    if (f.exp_one) begin
      if (f.man_zero) begin
        if (f.sign) cls[CLS_NINF] = 1'b1;
        else        cls[CLS_PINF] = 1'b1;
      end else if (f.man_msb) begin
        cls[CLS_QNAN] = 1'b1;
      end else begin
        cls[CLS_SNAN] = 1'b1;
      end
    end else if (f.exp_zero) begin
      // DAZ folds a subnormal into the zero of the same sign.
      if (f.man_zero || f.daz) begin
        if (f.sign) cls[CLS_NZERO] = 1'b1;
        else        cls[CLS_PZERO] = 1'b1;
      end else begin
        if (f.sign) cls[CLS_NSUB] = 1'b1;
        else        cls[CLS_PSUB] = 1'b1;
      end
    end else begin
      if (f.sign) cls[CLS_NNORM] = 1'b1;
      else        cls[CLS_PNORM] = 1'b1;
    end
    return cls;
  endfunction

  // Subnormal as seen on the wire, before DAZ is applied.
  function automatic logic raw_sub(input fields_t f);
    return f.exp_zero & ~f.man_zero;
  endfunction

endpackage

// File: rtl/fp_class_pipe_if.sv
// Operand/result handshake bundle for fp_class_pipe.
//   in_valid/in_ready/in_data/in_daz : operand channel (producer -> block)
//   out_valid/out_ready/out_class    : result channel (block -> consumer)
// master = environment side, slave = classifier side.
interface fp_class_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic                                in_valid;
  logic                                in_ready;
  logic [W-1:0]                        in_data;
  logic                                in_daz;
  logic                                out_valid;
  logic                                out_ready;
  logic [fp_class_pkg::NUM_CLASS-1:0]  out_class;

  modport master (
    output in_valid, in_data, in_daz, out_ready,
    input  in_ready, out_valid, out_class
  );

  modport slave (
    input  in_valid, in_data, in_daz, out_ready,
    output in_ready, out_valid, out_class
  );
endinterface

// File: rtl/fp_class_decode.sv
// Combinational field decode of one IEEE-754 operand.
//   data     : raw operand, sign at the top, then exponent, then mantissa
//   sign     : sign bit
//   exp_one  : exponent field all ones
//   exp_zero : exponent field all zeros
//   man_zero : mantissa field all zeros
//   man_msb  : top mantissa bit (quiet bit for NaNs)
module fp_class_decode #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] data,
  output logic                 sign,
  output logic                 exp_one,
  output logic                 exp_zero,
  output logic                 man_zero,
  output logic                 man_msb
);
  localparam int W = 1 + EXP_W + MAN_W;

  assign sign     = data[W-1];
  assign exp_one  = &data[W-2:MAN_W];
  assign exp_zero = ~|data[W-2:MAN_W];
  assign man_zero = ~|data[MAN_W-1:0];
  assign man_msb  = data[MAN_W-1];
endmodule

// File: rtl/fp_class_pipe.sv
// Two-stage IEEE-754 classifier with per-class event counters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : operand in (valid/ready/data/daz), one-hot class out
//   cnt_clr      : synchronous clear of counters and sticky flags
//   cnt_bus      : NUM_CLASS saturating counters, class k at [k*CNT_W +: CNT_W]
//   sticky_snan  : an sNaN was delivered since the last clear
//   sticky_sub   : a raw subnormal (ignoring DAZ) was delivered since the last clear
// S1 holds decoded fields + daz, S2 holds the one-hot class + raw-subnormal bit.
// Counters and flags only move on an output handshake.
module fp_class_pipe
  import fp_class_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fp_class_pipe_if.slave              bus,
  input  logic                        cnt_clr,
  output logic [NUM_CLASS*CNT_W-1:0]  cnt_bus,
  output logic                        sticky_snan,
  output logic                        sticky_sub
);
  localparam int W = 1 + EXP_W + MAN_W;

  if (!fmt_legal(EXP_W, MAN_W)) begin : g_bad_fmt
    $error("fp_class_pipe: EXP_W/MAN_W must be 5/10, 8/23 or 11/52");
  end

  logic [W-1:0] in_data_w;
  logic         d_sign, d_exp_one, d_exp_zero, d_man_zero, d_man_msb;
  fields_t      dec;

  assign in_data_w = bus.in_data;

  fp_class_decode #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_decode (
    .data     (in_data_w),
    .sign     (d_sign),
    .exp_one  (d_exp_one),
    .exp_zero (d_exp_zero),
    .man_zero (d_man_zero),
    .man_msb  (d_man_msb)
  );

  assign dec = {d_sign, d_exp_one, d_exp_zero, d_man_zero, d_man_msb, bus.in_daz};

  logic    s1_valid_q, s1_valid_d;
  fields_t s1_q, s1_d;
  logic    s2_valid_q, s2_valid_d;
  class_t  s2_class_q, s2_class_d;
  logic    s2_sub_q, s2_sub_d;

  logic [NUM_CLASS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic    snan_q, snan_d;
  logic    sub_q, sub_d;

  logic    s2_load;
  logic    in_ready_int;
  logic    out_hs;

  // Pipeline advance: S2 takes S1 whenever it is empty or being drained,
  // so S1 can accept a new operand in the same cycle it hands one down.
  always_comb begin
    s2_load      = ~s2_valid_q | bus.out_ready;
    in_ready_int = ~s1_valid_q | s2_load;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_class_d = s2_class_q;
    s2_sub_d   = s2_sub_q;

    if (in_ready_int) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_d = dec;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      // Bubbles leave the old class in place; it is masked by out_valid.
      if (s1_valid_q) begin
        s2_class_d = classify(s1_q);
        s2_sub_d   = raw_sub(s1_q);
      end
    end
  end

  // Event accounting; a clear in the same cycle swallows the event.
  always_comb begin
    out_hs = s2_valid_q & bus.out_ready;
    cnt_d  = cnt_q;
    snan_d = snan_q;
    sub_d  = sub_q;

    if (cnt_clr) begin
      cnt_d  = '0;
      snan_d = 1'b0;
      sub_d  = 1'b0;
    end else if (out_hs) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        if (s2_class_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
      if (s2_class_q[CLS_SNAN]) snan_d = 1'b1;
      if (s2_sub_q)             sub_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_class_q <= '0;
      s2_sub_q   <= 1'b0;
      cnt_q      <= '0;
      snan_q     <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_class_q <= s2_class_d;
      s2_sub_q   <= s2_sub_d;
      cnt_q      <= cnt_d;
      snan_q     <= snan_d;
      sub_q      <= sub_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_class = s2_class_q;

  // Packed array element k lands at [k*CNT_W +: CNT_W].
  assign cnt_bus     = cnt_q;
  assign sticky_snan = snan_q;
  assign sticky_sub  = sub_q;
endmodule

// File: tb/tb_fp_class_pipe.sv
// Bench for fp_class_pipe: single precision (CNT_W=16), single precision
// with CNT_W=2, and half precision. Expected classes come from a
// value-level model of the IEEE-754 rules; deliveries go through a queue.
module tb_fp_class_pipe;
  import fp_class_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_c_n;
  logic clr_a, clr_b, clr_c;
  logic [159:0] cnt_a, cnt_c;
  logic [19:0]  cnt_b;
  logic snan_a, sub_a, snan_b, sub_b, snan_c, sub_c;

  fp_class_pipe_if #(.EXP_W(8), .MAN_W(23)) if_a ();
  fp_class_pipe_if #(.EXP_W(8), .MAN_W(23)) if_b ();
  fp_class_pipe_if #(.EXP_W(5), .MAN_W(10)) if_c ();

  fp_class_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .cnt_clr(clr_a),
    .cnt_bus(cnt_a), .sticky_snan(snan_a), .sticky_sub(sub_a));
  fp_class_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .cnt_clr(clr_b),
    .cnt_bus(cnt_b), .sticky_snan(snan_b), .sticky_sub(sub_b));
  fp_class_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_c_n), .bus(if_c), .cnt_clr(clr_c),
    .cnt_bus(cnt_c), .sticky_snan(snan_c), .sticky_sub(sub_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: class index straight from the numeric fields.
  function automatic int ref_class(input logic [63:0] x, input int ew, input int mw, input bit daz);
    logic [63:0] e, m, emax;
    bit s;
    e    = (x >> mw) & ((64'd1 << ew) - 64'd1);
    m    = x & ((64'd1 << mw) - 64'd1);
    s    = x[ew+mw];
    emax = (64'd1 << ew) - 64'd1;
    if (e == emax) begin
      if (m == 0) return s ? 0 : 7;
      if (m >= (64'd1 << (mw - 1))) return 9;
      return 8;
    end
    if (e == 0) begin
      if (m == 0 || daz) return s ? 3 : 4;
      return s ? 2 : 5;
    end
    return s ? 1 : 6;
  endfunction

  function automatic bit ref_sub(input logic [63:0] x, input int ew, input int mw);
    logic [63:0] e, m;
    e = (x >> mw) & ((64'd1 << ew) - 64'd1);
    m = x & ((64'd1 << mw) - 64'd1);
    return (e == 0) && (m != 0);
  endfunction

  typedef struct { int cls; bit sub; } exp_t;
  exp_t qa[$];
  int   mcnt[10];
  bit   msnan, msub;
  bit   stall_prev;
  logic [9:0] stall_cls;
  bit   acc, dlv;

  // One clock of instance A: drive at negedge, sample 1ns later, score.
  task automatic step_a(input bit v, input logic [31:0] d, input bit daz,
                        input bit ordy, input bit clr, output bit a, output bit o);
    exp_t e;
    @(negedge clk);
    if_a.in_valid  = v;
    if_a.in_data   = d;
    if_a.in_daz    = daz;
    if_a.out_ready = ordy;
    clr_a          = clr;
    #1;
    if (stall_prev) begin
      chk("hold_valid", if_a.out_valid, 1);
      chk("hold_class", if_a.out_class, stall_cls);
    end
    a = v && (if_a.in_ready === 1'b1);
    o = (if_a.out_valid === 1'b1) && ordy;
    if (o) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra: delivered %0h expected nothing", if_a.out_class);
      end else begin
        e = qa.pop_front();
        chk("a_class", if_a.out_class, 64'd1 << e.cls);
        if (!clr) begin
          if (mcnt[e.cls] < 65535) mcnt[e.cls]++;
          if (e.cls == 8) msnan = 1'b1;
          if (e.sub)      msub  = 1'b1;
        end
      end
    end
    if (a) begin
      e.cls = ref_class(d, 8, 23, daz);
      e.sub = ref_sub(d, 8, 23);
      qa.push_back(e);
    end
    if (clr) begin
      for (int k = 0; k < 10; k++) mcnt[k] = 0;
      msnan = 1'b0;
      msub  = 1'b0;
    end
    stall_prev = (if_a.out_valid === 1'b1) && !ordy;
    stall_cls  = if_a.out_class;
  endtask

  task automatic check_cnt_a(input string tag);
    bit a2, o2;
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, a2, o2);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_cnt%0d", tag, k), cnt_a[k*16 +: 16], mcnt[k]);
    chk({tag, "_snan"}, snan_a, msnan);
    chk({tag, "_sub"}, sub_a, msub);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 3))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 2))
      0:       m = 23'd0;
      1:       m = {1'b1, 22'($urandom)};
      default: m = {1'b0, 22'($urandom)};
    endcase
    return {1'($urandom), e, m};
  endfunction

  typedef struct { logic [31:0] d; bit daz; logic [9:0] cls; } vec_t;
  vec_t tbl[16];
  logic [31:0] bp[6];

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int idx, nd;
    rst_n = 1'b0; rst_c_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    if_a.in_valid = 0; if_a.in_data = 0; if_a.in_daz = 0; if_a.out_ready = 0;
    if_b.in_valid = 0; if_b.in_data = 0; if_b.in_daz = 0; if_b.out_ready = 0;
    if_c.in_valid = 0; if_c.in_data = 0; if_c.in_daz = 0; if_c.out_ready = 0;
    stall_prev = 1'b0;
    for (int k = 0; k < 10; k++) mcnt[k] = 0;
    msnan = 0; msub = 0;

    tbl[0]  = '{32'h7F800000, 1'b0, 10'h080};
    tbl[1]  = '{32'hFF800000, 1'b0, 10'h001};
    tbl[2]  = '{32'h00000000, 1'b0, 10'h010};
    tbl[3]  = '{32'h80000001, 1'b0, 10'h004};
    tbl[4]  = '{32'h7FA00000, 1'b0, 10'h100};
    tbl[5]  = '{32'h7FC00000, 1'b0, 10'h200};
    tbl[6]  = '{32'h00000001, 1'b1, 10'h010};
    tbl[7]  = '{32'h3F800000, 1'b0, 10'h040};
    tbl[8]  = '{32'hBF800000, 1'b0, 10'h002};
    tbl[9]  = '{32'h00000001, 1'b0, 10'h020};
    tbl[10] = '{32'hFFC00000, 1'b0, 10'h200};
    tbl[11] = '{32'hFF800001, 1'b0, 10'h100};
    tbl[12] = '{32'h80000000, 1'b0, 10'h008};
    tbl[13] = '{32'h80000001, 1'b1, 10'h008};
    tbl[14] = '{32'h7F7FFFFF, 1'b0, 10'h040};
    tbl[15] = '{32'h00800000, 1'b0, 10'h040};
    bp = '{32'h3F800000, 32'h7F800000, 32'h80000000, 32'h00000005, 32'hBF800000, 32'h7FC00000};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_out_class", if_a.out_class, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_snan", snan_a, 0);
    chk("rst_sub", sub_a, 0);
    @(negedge clk);
    rst_n = 1'b1; rst_c_n = 1'b1;
    #1;
    chk("rst_in_ready", if_a.in_ready, 1);

    // Table stream, back-to-back, out_ready held high: 2-cycle latency.
    for (int i = 0; i < 18; i++) begin
      step_a(i < 16, (i < 16) ? tbl[i].d : 32'd0, (i < 16) ? tbl[i].daz : 1'b0,
             1'b1, 1'b0, acc, dlv);
      if (i < 16) chk($sformatf("tbl_acc%0d", i), acc, 1);
      if (i >= 2) begin
        chk($sformatf("tbl_lat%0d", i - 2), dlv, 1);
        chk($sformatf("tbl_cls%0d", i - 2), if_a.out_class, tbl[i-2].cls);
      end else begin
        chk($sformatf("tbl_early%0d", i), if_a.out_valid, 0);
      end
    end
    check_cnt_a("tbl");

    // sNaN then qNaN; sticky_snan rises only on delivery.
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, acc, dlv);
    step_a(1'b1, 32'h7FA00000, 1'b0, 1'b1, 1'b0, acc, dlv);
    step_a(1'b1, 32'h7FC00000, 1'b0, 1'b1, 1'b0, acc, dlv);
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, acc, dlv);
    chk("snan_before", snan_a, 0);
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, acc, dlv);
    chk("snan_after", snan_a, 1);
    check_cnt_a("nan");

    // DAZ subnormal: counts as +zero, still raises sticky_sub.
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, acc, dlv);
    step_a(1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0, acc, dlv);
    repeat (2) step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, acc, dlv);
    check_cnt_a("daz");
    chk("daz_cnt4", cnt_a[4*16 +: 16], 1);
    chk("daz_cnt5", cnt_a[5*16 +: 16], 0);
    chk("daz_sub", sub_a, 1);

    // Backpressure: out_ready low for 5 cycles with a full stream offered.
    step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, acc, dlv);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step_a(1'b1, bp[idx], 1'b0, 1'b0, 1'b0, acc, dlv);
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", if_a.in_ready, 0);
    for (int c = 0; c < 16; c++) begin
      step_a(idx < 6, (idx < 6) ? bp[idx] : 32'd0, 1'b0, 1'b1, 1'b0, acc, dlv);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 6);
    chk("bp_drained", qa.size(), 0);
    check_cnt_a("bp");

    // Random traffic with random stalls and occasional clears.
    for (int c = 0; c < 500; c++) begin
      step_a($urandom_range(0, 9) < 7, rnd_fp(), 1'($urandom), $urandom_range(0, 9) < 6,
             $urandom_range(0, 49) == 0, acc, dlv);
    end
    for (int c = 0; c < 6; c++) step_a(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, acc, dlv);
    chk("rnd_drained", qa.size(), 0);
    check_cnt_a("rnd");

    // CNT_W=2 saturation, then clear colliding with a delivery.
    if_b.out_ready = 1'b1;
    if_b.in_data   = 32'h3F800000;
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if_b.in_valid = (i < 5);
      #1;
      if (if_b.out_valid === 1'b1) nd++;
    end
    @(negedge clk);
    #1;
    chk("sat_deliveries", nd, 5);
    chk("sat_cnt6", cnt_b[6*2 +: 2], 3);
    chk("sat_idle", if_b.out_valid, 0);
    @(negedge clk); if_b.in_valid = 1'b1;
    @(negedge clk); if_b.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("clr_hs_valid", if_b.out_valid, 1);
    clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0; #1;
    chk("clr_cnt6", cnt_b[6*2 +: 2], 0);
    chk("clr_all", cnt_b, 0);
    chk("clr_out_valid", if_b.out_valid, 0);

    // Half precision classes.
    if_c.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] hv[3];
      hv = '{16'h7C00, 16'h7E00, 16'h0200};
      @(negedge clk);
      if_c.in_valid = (i < 3);
      if (i < 3) if_c.in_data = hv[i];
      #1;
      if (i >= 2) begin
        chk($sformatf("half_valid%0d", i - 2), if_c.out_valid, 1);
        chk($sformatf("half_cls%0d", i - 2), if_c.out_class,
            64'd1 << ref_class({48'd0, hv[i-2]}, 5, 10, 1'b0));
      end
    end

    // Reset with two operands in flight: nothing may come out afterwards.
    @(negedge clk);
    if_c.in_valid = 1'b1; if_c.in_data = 16'h3C00;
    @(negedge clk);
    if_c.in_data = 16'hFC00;
    @(negedge clk);
    if_c.in_valid = 1'b0;
    #2;
    rst_c_n = 1'b0;
    #1;
    chk("midrst_valid", if_c.out_valid, 0);
    chk("midrst_class", if_c.out_class, 0);
    @(negedge clk);
    rst_c_n = 1'b1;
    #1;
    chk("midrst_in_ready", if_c.in_ready, 1);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (if_c.out_valid === 1'b1) nd++;
    end
    chk("midrst_stale", nd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_class_pipe.md
FP_CLASS_PIPE -- requirements
Module: fp_class_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; legal values 5, 8 and 11.
REQ-002 Parameter MAN_W, default 23, mantissa field width; legal values 10, 23 and 52.
REQ-003 Parameter CNT_W, default 16, width of each per-class event counter.
REQ-004 Derived width W = 1+EXP_W+MAN_W; sign is bit W-1, exponent is [W-2:MAN_W], mantissa is [MAN_W-1:0].
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 in_valid  in  1  input operand valid.
REQ-008 in_ready  out  1  block accepts an operand this cycle.
REQ-009 in_data  in  W  IEEE-754 operand.
REQ-010 in_daz  in  1  denormals-are-zero; sampled together with in_data.
REQ-011 out_valid  out  1  classification valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_class  out  10  one-hot class, bit order below.
REQ-014 cnt_clr  in  1  synchronous clear of all counters and sticky flags.
REQ-015 cnt_bus  out  10*CNT_W  per-class counters; class k occupies [k*CNT_W +: CNT_W].
REQ-016 sticky_snan  out  1  an sNaN has been delivered since the last clear.
REQ-017 sticky_sub  out  1  a subnormal (before DAZ) has been delivered since the last clear.

Function
REQ-018 out_class bits 0..9 SHALL be: -inf, -normal, -subnormal, -zero, +zero, +subnormal, +normal, +inf, sNaN, qNaN.
REQ-019 Each result SHALL have exactly one out_class bit set; NaN classes ignore the sign bit.
REQ-020 Decode: expOne means exponent all ones; expZero means exponent all zeros; manZero means mantissa all zeros.
REQ-021 Classes: sNaN = expOne & !manZero & !man[MAN_W-1]; qNaN = expOne & man[MAN_W-1]; inf = expOne & manZero; zero = expZero & manZero; subnormal = expZero & !manZero; otherwise normal.
REQ-022 With in_daz=1, a subnormal operand SHALL be classified as zero of the same sign.
REQ-023 Pipeline: two register stages. Stage S1 holds the decoded fields and the daz bit. Stage S2 holds out_class and an internal raw-subnormal bit.
REQ-024 Latency SHALL be 2 cycles from the input handshake to out_valid while out_ready=1; throughput SHALL be 1 operand per cycle.
REQ-025 S2 SHALL load when it is empty or out_ready=1; S1 SHALL advance when S2 loads; in_ready = !S1_valid | S2_load.
REQ-026 While out_valid=1 and out_ready=0, out_class SHALL hold stable, and no operand may be lost or duplicated.
REQ-027 On each output handshake (out_valid & out_ready), the counter of the delivered class SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-028 On the same handshake, sticky_snan SHALL set if the class is sNaN, and sticky_sub SHALL set if the raw operand was subnormal, regardless of DAZ.
REQ-029 If cnt_clr and a handshake occur in the same cycle, clear SHALL win: counters and sticky flags become 0 and the event is dropped.
REQ-030 cnt_clr SHALL NOT affect pipeline contents or the handshake signals.

Reset
REQ-031 While rst_n=0, the block SHALL force: S1/S2 valid=0, out_valid=0, out_class=0, all counters=0, sticky flags=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-033 An operand in flight when reset asserts SHALL be discarded and never delivered.

Structure
REQ-034 Package fp_class_pkg SHALL hold the class index constants (CLS_NINF=0 .. CLS_QNAN=9), NUM_CLASS=10, and the legal-format width constants (half, single, double).
REQ-035 Sub-module fp_class_decode SHALL be combinational and parameterised by EXP_W and MAN_W; it outputs sign, expOne, expZero, manZero and manMsb.
REQ-036 A parameter combination other than 5/10, 8/23 or 11/52 SHALL raise an elaboration-time error.

Verification
REQ-037 Default params, out_ready=1, inputs 0x7F800000, 0xFF800000, 0x00000000, 0x80000001 -> out_class 0x080, 0x001, 0x010, 0x004 delivered 2 cycles after each input.
REQ-038 Inputs 0x7FA00000 then 0x7FC00000 -> out_class 0x100 then 0x200; sticky_snan=1 after the first delivery.
REQ-039 Input 0x00000001 with in_daz=1 -> out_class 0x010 (+zero); sticky_sub=1; counter 4 increments and counter 5 does not.
REQ-040 Back-to-back stream with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; out_class stays stable; stream order is preserved once out_ready returns.
REQ-041 CNT_W=2, 5 deliveries of 0x3F800000 -> counter 6 = 3 (saturated); cnt_clr pulsed together with a 6th delivery -> counter 6 = 0.
REQ-042 EXP_W=5, MAN_W=10 with inputs 0x7C00, 0x7E00, 0x0200 -> +inf, qNaN, +subnormal; rst_n pulsed mid-stream -> out_valid=0 and no stale result is delivered.
